// File: rtl/sdram_word_bridge.sv
`default_nettype none
// ============================================================================
// sdram_word_bridge : splits 32-bit CPU load/store accesses into little-endian
// single-byte transactions for the byte-wide sdram_controller, with watchdog.
// Revision: 1.0
// ============================================================================
module sdram_word_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [22:0] i_cpu_addr,
    input  logic [3:0]  i_cpu_be,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_done,
    output logic        o_cpu_error,
    output logic        o_busy,
    output logic        o_sd_request,
    output logic        o_sd_wren,
    output logic [22:0] o_sd_address,
    output logic [7:0]  o_sd_data,
    input  logic [7:0]  i_sd_data,
    input  logic        i_sd_done
);

    localparam logic [15:0] C_WDOG_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [20:0] base_q, base_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        err_q, err_d;
    logic [15:0] wdog_q, wdog_d;

    logic        sd_request_q, sd_request_d;
    logic        sd_wren_q, sd_wren_d;
    logic [22:0] sd_address_q, sd_address_d;
    logic [7:0]  sd_data_q, sd_data_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        cpu_done_q, cpu_done_d;
    logic        cpu_error_q, cpu_error_d;
    logic        busy_q, busy_d;

    logic [4:0]  w_byte_lo;
    logic        w_unused_addr;

    assign w_byte_lo     = {idx_q, 3'b000};
    assign w_unused_addr = ^i_cpu_addr[1:0];

    // Outputs are registered, so each is computed from the state being entered.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        base_d       = base_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        err_d        = err_q;
        wdog_d       = wdog_q;
        sd_request_d = 1'b0;
        sd_wren_d    = sd_wren_q;
        sd_address_d = sd_address_q;
        sd_data_d    = sd_data_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_done_d   = 1'b0;
        cpu_error_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_cpu_req) begin
                    base_d      = i_cpu_addr[22:2];
                    we_d        = i_cpu_we;
                    wdata_d     = i_cpu_wdata;
                    mask_d      = i_cpu_we ? i_cpu_be : 4'b1111;
                    idx_d       = 2'd0;
                    cpu_rdata_d = 32'd0;
                    err_d       = 1'b0;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                if (mask_q[idx_q]) begin
                    state_d      = S_ISSUE;
                    sd_request_d = 1'b1;
                    sd_address_d = {base_q, idx_q};
                    sd_wren_d    = we_q;
                    sd_data_d    = wdata_q[w_byte_lo +: 8];
                end else if (idx_q == 2'd3) begin
                    state_d     = S_FINISH;
                    cpu_done_d  = 1'b1;
                    cpu_error_d = err_q;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            S_ISSUE: begin
                wdog_d  = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving in the expiry cycle still counts as success.
                if (i_sd_done) begin
                    if (!we_q) begin
                        cpu_rdata_d[w_byte_lo +: 8] = i_sd_data;
                    end
                    if (idx_q == 2'd3) begin
                        state_d     = S_FINISH;
                        cpu_done_d  = 1'b1;
                        cpu_error_d = err_q;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_SCAN;
                    end
                end else if (wdog_q + 16'd1 == C_WDOG_LIMIT) begin
                    err_d       = 1'b1;
                    state_d     = S_FINISH;
                    cpu_done_d  = 1'b1;
                    cpu_error_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            base_q       <= 21'd0;
            we_q         <= 1'b0;
            wdata_q      <= 32'd0;
            mask_q       <= 4'd0;
            err_q        <= 1'b0;
            wdog_q       <= 16'd0;
            sd_request_q <= 1'b0;
            sd_wren_q    <= 1'b0;
            sd_address_q <= 23'd0;
            sd_data_q    <= 8'd0;
            cpu_rdata_q  <= 32'd0;
            cpu_done_q   <= 1'b0;
            cpu_error_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            base_q       <= base_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            err_q        <= err_d;
            wdog_q       <= wdog_d;
            sd_request_q <= sd_request_d;
            sd_wren_q    <= sd_wren_d;
            sd_address_q <= sd_address_d;
            sd_data_q    <= sd_data_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_done_q   <= cpu_done_d;
            cpu_error_q  <= cpu_error_d;
            busy_q       <= busy_d;
        end
    end

    assign o_sd_request = sd_request_q;
    assign o_sd_wren    = sd_wren_q;
    assign o_sd_address = sd_address_q;
    assign o_sd_data    = sd_data_q;
    assign o_cpu_rdata  = cpu_rdata_q;
    assign o_cpu_done   = cpu_done_q;
    assign o_cpu_error  = cpu_error_q;
    assign o_busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_word_bridge.sv
`default_nettype none
// tb_sdram_word_bridge: directed and randomized accesses checked against a
// behavioural byte-SDRAM model and a spec-level timing/result predictor.
module tb_sdram_word_bridge;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [22:0] cpu_addr;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done, cpu_error, busy;
    logic        sd_request, sd_wren;
    logic [22:0] sd_address;
    logic [7:0]  sd_wdata;
    logic [7:0]  sd_rdata;
    logic        sd_done;

    // controller model state
    logic [7:0]  mem [0:1023];
    int          lat_cfg [4];
    logic        mdone = 1'b0;
    logic [7:0]  mdata = 8'd0;
    logic        spur_done = 1'b0;
    bit          pend = 1'b0;
    bit          prev_req = 1'b0;
    int          cnt = 0;
    logic [9:0]  maddr;
    logic        mwr;
    logic [7:0]  mdat;
    int          viol = 0;
    logic [31:0] req_log [$];

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          last_cyc;
    logic [31:0] last_rd;
    logic        last_err;

    assign sd_done  = mdone | spur_done;
    assign sd_rdata = spur_done ? 8'hEE : mdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_word_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_be(cpu_be), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_done(cpu_done), .o_cpu_error(cpu_error),
        .o_busy(busy), .o_sd_request(sd_request), .o_sd_wren(sd_wren),
        .o_sd_address(sd_address), .o_sd_data(sd_wdata),
        .i_sd_data(sd_rdata), .i_sd_done(sd_done)
    );

    // Byte controller: done D cycles after the request cycle; never reset.
    always @(negedge clk) begin
        mdone = 1'b0;
        if (pend) begin
            if (cnt <= 1) begin
                mdone = 1'b1;
                mdata = mem[maddr];
                if (mwr) mem[maddr] = mdat;
                pend = 1'b0;
            end else begin
                cnt = cnt - 1;
            end
        end
        if (sd_request) begin
            if (prev_req || pend) viol = viol + 1;
            req_log.push_back({sd_address, sd_wren, sd_wdata});
            pend  = 1'b1;
            cnt   = lat_cfg[sd_address[1:0]];
            maddr = sd_address[9:0];
            mwr   = sd_wren;
            mdat  = sd_wdata;
        end
        prev_req = sd_request;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_quiet();
        for (int n = 0; n < 100 && pend; n++) @(posedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_access(input string name, input bit we, input logic [22:0] addr,
                              input logic [3:0] be, input logic [31:0] wd,
                              input bit hold_req, input bit spur);
        logic [22:0] base;
        logic [3:0]  mask;
        logic [7:0]  snap [4];
        bit          issued [4];
        logic [31:0] exp_q [$];
        logic [31:0] exp_rd;
        int          exp_cyc;
        bit          abort;
        int          start;

        base = {addr[22:2], 2'b00};
        mask = we ? be : 4'b1111;
        for (int k = 0; k < 4; k++) begin
            snap[k]   = mem[{base[9:2], 2'(k)}];
            issued[k] = 1'b0;
        end
        // Each byte: one SCAN, plus ISSUE and D WAIT cycles when enabled.
        exp_cyc = 1;
        abort   = 1'b0;
        exp_rd  = 32'd0;
        for (int k = 0; k < 4 && !abort; k++) begin
            exp_cyc += 1;
            if (mask[k]) begin
                issued[k] = 1'b1;
                exp_q.push_back({base[22:2], 2'(k), we, wd[8*k +: 8]});
                if (lat_cfg[k] > TMO) begin
                    exp_cyc += 1 + TMO;
                    abort = 1'b1;
                end else begin
                    exp_cyc += 1 + lat_cfg[k];
                    if (!we) exp_rd[8*k +: 8] = snap[k];
                end
            end
        end

        @(negedge clk);
        req_log.delete();
        viol      = 0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_be    = be;
        cpu_wdata = wd;
        start     = cyc;
        last_cyc  = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!hold_req) cpu_req = 1'b0;
            spur_done = spur && (cyc - start == 1);
            if (cpu_done) begin
                last_cyc = cyc - start;
                last_rd  = cpu_rdata;
                last_err = cpu_error;
                break;
            end
        end
        cpu_req   = 1'b0;
        spur_done = 1'b0;
        @(negedge clk);
        check({name, "_idle_after"}, {busy, cpu_done}, 0);
        wait_quiet();

        check({name, "_done_cycle"}, last_cyc, exp_cyc);
        check({name, "_error"}, last_err, abort);
        if (!we) check({name, "_rdata"}, last_rd, exp_rd);
        check({name, "_nreq"}, req_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < req_log.size(); i++)
            check({name, "_req"}, req_log[i], exp_q[i]);
        check({name, "_spacing"}, viol, 0);
        if (we) begin
            for (int k = 0; k < 4; k++)
                check({name, "_mem"}, mem[{base[9:2], 2'(k)}],
                      issued[k] ? wd[8*k +: 8] : snap[k]);
        end
    endtask

    initial begin
        bit quiet;
        int start;
        for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
        lat_cfg   = '{1, 1, 1, 1};
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 23'd0;
        cpu_be    = 4'd0;
        cpu_wdata = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_ctl", {sd_request, sd_wren, cpu_done, cpu_error, busy, sd_address, sd_wdata}, 0);
        check("reset_rdata", cpu_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // word load, D=9: completion pulse at cycle 45
        mem[10'h104] = 8'h11; mem[10'h105] = 8'h22;
        mem[10'h106] = 8'h33; mem[10'h107] = 8'h44;
        lat_cfg = '{9, 9, 9, 9};
        run_access("word_load", 1'b0, 23'h000104, 4'h0, 32'h0, 1'b0, 1'b0);
        check("word_load_value", last_rd, 32'h44332211);
        check("word_load_latency", last_cyc, 45);

        // partial store
        lat_cfg = '{4, 5, 6, 7};
        run_access("part_store", 1'b1, 23'h000203, 4'b1010, 32'hAABBCCDD, 1'b0, 1'b0);
        check("part_store_w0", req_log.size() > 0 ? req_log[0] : 0, {23'h201, 1'b1, 8'hCC});
        check("part_store_w1", req_log.size() > 1 ? req_log[1] : 0, {23'h203, 1'b1, 8'hAA});

        // empty store
        run_access("empty_store", 1'b1, 23'h000310, 4'b0000, 32'h12345678, 1'b0, 1'b0);
        check("empty_store_cycle", last_cyc, 5);

        // timeout on byte 1; the late controller done lands in IDLE
        lat_cfg = '{3, 30, 3, 3};
        run_access("timeout", 1'b0, 23'h000420, 4'h0, 32'h0, 1'b0, 1'b0);
        check("timeout_err", last_err, 1);
        check("timeout_rdata", last_rd, {24'h0, mem[10'h020]});

        // done exactly at the watchdog limit resolves as success
        lat_cfg = '{TMO, 2, TMO, 2};
        run_access("edge_limit", 1'b0, 23'h000530, 4'h0, 32'h0, 1'b0, 1'b0);

        // held request plus a stray done during SCAN
        lat_cfg = '{2, 3, 2, 3};
        run_access("abuse", 1'b0, 23'h000644, 4'h0, 32'h0, 1'b1, 1'b1);

        // reset during WAIT of byte 2
        lat_cfg = '{6, 6, 6, 6};
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 23'h000750;
        start    = cyc;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            cpu_req = 1'b0;
        end
        check("rst_in_wait", {busy, cyc - start}, {1'b1, 32'd20});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_ctl", {sd_request, sd_wren, cpu_done, cpu_error, busy, sd_address, sd_wdata}, 0);
        check("rst_mid_rdata", cpu_rdata, 0);
        quiet = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (busy || cpu_done || sd_request || cpu_rdata != 32'd0) quiet = 1'b0;
        end
        check("rst_stale_done_ignored", quiet, 1);
        wait_quiet();
        lat_cfg = '{2, 4, 3, 5};
        run_access("post_reset_load", 1'b0, 23'h000750, 4'h0, 32'h0, 1'b0, 1'b0);

        // randomized accesses
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < 4; k++) lat_cfg[k] = $urandom_range(1, TMO);
            if ($urandom_range(0, 4) == 0) lat_cfg[$urandom_range(0, 3)] = 25;
            run_access("rand", 1'($urandom_range(0, 1)), 23'($urandom), 4'($urandom),
                       $urandom, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
